counter_modulo_down_sync: RTL and testbench



---
 rtl/counter_pkg.sv | 9 +
 rtl/counter_modulo_down_sync_if.sv | 16 +
 rtl/counter_modulo_down_sync.sv | 71 +++++++
 tb/tb_counter_modulo_down_sync.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: FSM state encoding and load clamping shared by the modulo down counter
package counter_pkg;
    typedef logic [0:0] state_t;
    localparam state_t ST_RUN  = 1'b0;
    localparam state_t ST_DONE = 1'b1;
    function automatic int clamp_load(input int value, input int modulus);
        return (value >= modulus) ? modulus - 1 : value;
    endfunction
endpackage

// File: rtl/counter_modulo_down_sync_if.sv
// counter_modulo_down_sync_if: control inputs and count outputs of the modulo down counter
interface counter_modulo_down_sync_if #(parameter int WIDTH = 2);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             oneshot;
    logic [WIDTH-1:0] signal_q;
    logic [WIDTH-1:0] signal_q_;
    logic             borrow;
    logic             terminal;
    logic             done;
    modport master (output enable, load, load_value, oneshot,
                    input signal_q, signal_q_, borrow, terminal, done);
    modport slave  (input enable, load, load_value, oneshot,
                    output signal_q, signal_q_, borrow, terminal, done);
endinterface

// File: rtl/counter_modulo_down_sync.sv
// counter_modulo_down_sync: modulo-N down counter with load, borrow pulse and one-shot stop
// COUNTER_AUTORELOAD_EN: wrap reloads the last clamped load value instead of MODULUS-1
module counter_modulo_down_sync
    import counter_pkg::*;
#(
    parameter int MODULUS = 3,
    parameter int WIDTH   = 2
) (
    input logic                        clockpulse,
    input logic                        clear,
    counter_modulo_down_sync_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
        $error("counter_modulo_down_sync: need 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] r_q;
    logic             r_borrow;
    state_t           r_state;
    logic [WIDTH-1:0] w_clamped;
    logic [WIDTH-1:0] w_wrap;
    logic             w_step;

    assign w_clamped = WIDTH'(clamp_load(int'(bus.load_value), MODULUS));
    assign w_step    = bus.enable && (r_state == ST_RUN);

`ifdef COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] r_reload;
    always_ff @(posedge clockpulse) begin
        if (clear)
            r_reload <= MAX;
        else if (bus.load)
            r_reload <= w_clamped;
    end
    assign w_wrap = r_reload;
`else
    assign w_wrap = MAX;
`endif

    // zero is handled before the decrement so the count never underflows
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            r_q      <= MAX;
            r_state  <= ST_RUN;
            r_borrow <= 1'b0;
        end else if (bus.load) begin
            r_q      <= w_clamped;
            r_state  <= ST_RUN;
            r_borrow <= 1'b0;
        end else if (w_step && r_q == '0) begin
            r_borrow <= 1'b1;
            if (bus.oneshot)
                r_state <= ST_DONE;
            else
                r_q <= w_wrap;
        end else if (w_step) begin
            r_q      <= r_q - WIDTH'(1);
            r_borrow <= 1'b0;
        end else begin
            r_borrow <= 1'b0;
        end
    end

    assign bus.signal_q  = r_q;
    assign bus.signal_q_ = ~r_q;
    assign bus.borrow    = r_borrow;
    assign bus.terminal  = (r_q == '0);
    assign bus.done      = (r_state == ST_DONE);
endmodule

// File: tb/tb_counter_modulo_down_sync.sv
// tb_counter_modulo_down_sync: directed vectors checked against an integer model of the counter
module tb_counter_modulo_down_sync;
    localparam int M = 3;
    localparam int W = 2;

    logic clk;
    logic clear;
    int   n_checks;
    int   n_fail;

    counter_modulo_down_sync_if #(.WIDTH(W)) bus ();

    counter_modulo_down_sync #(.MODULUS(M), .WIDTH(W)) dut (
        .clockpulse(clk),
        .clear     (clear),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int m_q;
    int m_borrow;
    int m_done;
    int m_reload;
    bit m_valid;

`ifdef COUNTER_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    initial begin
        m_valid = 1'b0;
        n_checks = 0;
        n_fail = 0;
    end

    // Counter behaviour stated as plain integer arithmetic on the sampled inputs
    always @(posedge clk) begin
        if (clear) begin
            m_q <= M - 1; m_done <= 0; m_borrow <= 0; m_reload <= M - 1; m_valid <= 1'b1;
        end else if (bus.load) begin
            m_q <= (int'(bus.load_value) >= M) ? M - 1 : int'(bus.load_value);
            m_reload <= (int'(bus.load_value) >= M) ? M - 1 : int'(bus.load_value);
            m_done <= 0; m_borrow <= 0;
        end else if (bus.enable && m_done == 0) begin
            m_borrow <= (m_q == 0) ? 1 : 0;
            m_done <= (m_q == 0 && bus.oneshot) ? 1 : 0;
            m_q <= (m_q > 0) ? m_q - 1 : (bus.oneshot ? 0 : (AUTO ? m_reload : M - 1));
        end else begin
            m_borrow <= 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_q", int'(bus.signal_q), m_q);
            chk("model_q_", int'(bus.signal_q_), ((1 << W) - 1) ^ m_q);
            chk("model_borrow", int'(bus.borrow), m_borrow);
            chk("model_terminal", int'(bus.terminal), (m_q == 0) ? 1 : 0);
            chk("model_done", int'(bus.done), m_done);
        end
    end

    task automatic step(input logic c, input logic l, input logic [W-1:0] v,
                        input logic e, input logic o);
        clear = c;
        bus.load = l;
        bus.load_value = v;
        bus.enable = e;
        bus.oneshot = o;
        @(posedge clk);
        @(negedge clk);
    endtask

    int exp_q2[6] = '{1, 0, 2, 1, 0, 2};
    int exp_b2[6] = '{0, 0, 1, 0, 0, 1};
    int exp_q3[5] = '{1, 0, 0, 0, 0};
    int exp_d3[5] = '{0, 0, 1, 1, 1};
    int exp_b3[5] = '{0, 0, 1, 0, 0};
    int exp_q6[4];
    int exp_b6[4];

    initial begin
        step(1, 0, 0, 0, 0);
        chk("reset_q", int'(bus.signal_q), 2);
        chk("reset_q_", int'(bus.signal_q_), 1);
        chk("reset_borrow", int'(bus.borrow), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_terminal", int'(bus.terminal), 0);

        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 0);
            chk("wrap_q", int'(bus.signal_q), exp_q2[i]);
            chk("wrap_borrow", int'(bus.borrow), exp_b2[i]);
        end

        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 1);
            chk("oneshot_q", int'(bus.signal_q), exp_q3[i]);
            chk("oneshot_done", int'(bus.done), exp_d3[i]);
            chk("oneshot_borrow", int'(bus.borrow), exp_b3[i]);
        end
        step(0, 0, 0, 0, 1);
        chk("done_hold_noen", int'(bus.done), 1);

        step(0, 1, 1, 1, 1);
        chk("load_from_done_q", int'(bus.signal_q), 1);
        chk("load_from_done_done", int'(bus.done), 0);
        chk("load_from_done_borrow", int'(bus.borrow), 0);
        step(0, 1, 3, 1, 0);
        chk("load_clamp_q", int'(bus.signal_q), 2);
        step(0, 1, 2, 0, 0);
        chk("load_max_q", int'(bus.signal_q), 2);

        step(0, 0, 0, 1, 0);
        chk("pre_hold_q", int'(bus.signal_q), 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            chk("hold_q", int'(bus.signal_q), 1);
            chk("hold_borrow", int'(bus.borrow), 0);
        end
        step(1, 1, 0, 1, 0);
        chk("clear_beats_load_q", int'(bus.signal_q), 2);

        step(0, 1, 1, 1, 0);
        chk("load1_q", int'(bus.signal_q), 1);
        if (AUTO) begin
            exp_q6 = '{0, 1, 0, 1};
            exp_b6 = '{0, 1, 0, 1};
        end else begin
            exp_q6 = '{0, 2, 1, 0};
            exp_b6 = '{0, 1, 0, 0};
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0);
            chk("reload_q", int'(bus.signal_q), exp_q6[i]);
            chk("reload_borrow", int'(bus.borrow), exp_b6[i]);
        end

        step(0, 1, 0, 0, 0);
        chk("load0_terminal", int'(bus.terminal), 1);
        step(0, 0, 0, 1, 0);
        chk("load0_wrap_borrow", int'(bus.borrow), 1);
        step(0, 0, 0, 1, 0);
        if (AUTO) chk("load0_wrap_q", int'(bus.signal_q), 0);
        else chk("load0_wrap_q", int'(bus.signal_q), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
